// File: rtl/sa_input_skewer.sv
// Diagonal-wavefront feeder for the systolic mesh: lane i is delayed i cycles behind lane 0.
// Optional SKEW_ZERO_BUBBLE_EN forces operand/control fields of bubble stages to zero.
module sa_input_skewer #(
    parameter int LANES   = 8,
    parameter int DW      = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      in_a,
    input  logic [LANES*DW-1:0]      in_d,
    input  logic                     in_propagate,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic                     in_last,
    output logic [LANES*DW-1:0]      out_a,
    output logic [LANES*DW-1:0]      out_d,
    output logic [LANES-1:0]         out_propagate,
    output logic [LANES*SHIFT_W-1:0] out_shift,
    output logic [LANES-1:0]         out_valid,
    output logic                     busy
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rst_done;
    logic               accept;

    logic [LANES*DW-1:0] a_head;
    logic [LANES*DW-1:0] d_head;
    logic                prop_head;
    logic [SHIFT_W-1:0]  shift_head;

    assign accept   = in_valid & in_ready;
    // rst_done keeps in_ready low until the first edge after reset release
    assign in_ready = rst_done && (state != DRAIN);
    assign busy     = (state != IDLE) || (|out_valid);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (!in_last) begin
                        state_nxt = STREAM;
                    end else if (LANES > 1) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(LANES - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                // exit on the cycle the counter would hit zero: LANES-1 DRAIN cycles total
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
`ifdef SKEW_ZERO_BUBBLE_EN
        a_head     = accept ? in_a : '0;
        d_head     = accept ? in_d : '0;
        prop_head  = accept ? in_propagate : 1'b0;
        shift_head = accept ? in_shift : '0;
`else
        a_head     = in_a;
        d_head     = in_d;
        prop_head  = in_propagate;
        shift_head = in_shift;
`endif
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0]      a_pipe     [0:i];
        logic [DW-1:0]      d_pipe     [0:i];
        logic               prop_pipe  [0:i];
        logic [SHIFT_W-1:0] shift_pipe [0:i];
        logic               vld_pipe   [0:i];

        // stage 0 captures the head; stage s takes stage s-1
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int s = 0; s <= i; s++) begin
                    a_pipe[s]     <= '0;
                    d_pipe[s]     <= '0;
                    prop_pipe[s]  <= 1'b0;
                    shift_pipe[s] <= '0;
                    vld_pipe[s]   <= 1'b0;
                end
            end else begin
                a_pipe[0]     <= a_head[i*DW +: DW];
                d_pipe[0]     <= d_head[i*DW +: DW];
                prop_pipe[0]  <= prop_head;
                shift_pipe[0] <= shift_head;
                vld_pipe[0]   <= accept;
                for (int s = 1; s <= i; s++) begin
                    a_pipe[s]     <= a_pipe[s-1];
                    d_pipe[s]     <= d_pipe[s-1];
                    prop_pipe[s]  <= prop_pipe[s-1];
                    shift_pipe[s] <= shift_pipe[s-1];
                    vld_pipe[s]   <= vld_pipe[s-1];
                end
            end
        end

        assign out_a[i*DW +: DW]           = a_pipe[i];
        assign out_d[i*DW +: DW]           = d_pipe[i];
        assign out_propagate[i]            = prop_pipe[i];
        assign out_shift[i*SHIFT_W +: SHIFT_W] = shift_pipe[i];
        assign out_valid[i]                = vld_pipe[i];
    end

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer: reset, full tile, bubbles, back-to-back, single beat, mid-tile reset.
module tb_sa_input_skewer;
    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int SW    = 6;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_a;
    logic [LANES*DW-1:0]   in_d;
    logic                  in_propagate;
    logic [SW-1:0]         in_shift;
    logic                  in_last;
    logic [LANES*DW-1:0]   out_a;
    logic [LANES*DW-1:0]   out_d;
    logic [LANES-1:0]      out_propagate;
    logic [LANES*SW-1:0]   out_shift;
    logic [LANES-1:0]      out_valid;
    logic                  busy;

    int n_chk  = 0;
    int n_fail = 0;

    sa_input_skewer #(.LANES(LANES), .DW(DW), .SHIFT_W(SW)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_d(in_d), .in_propagate(in_propagate),
        .in_shift(in_shift), .in_last(in_last),
        .out_a(out_a), .out_d(out_d), .out_propagate(out_propagate),
        .out_shift(out_shift), .out_valid(out_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] lane_a(input int i);
        return out_a[i*DW +: DW];
    endfunction

    function automatic logic [SW-1:0] lane_sh(input int i);
        return out_shift[i*SW +: SW];
    endfunction

    function automatic logic [LANES*DW-1:0] pattern(input int b);
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(16 * b + i);
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk_eq("idle_reached", busy, 0);
    endtask

    logic [LANES-1:0] exp_v;
    int tA, tB, pos, viol;

    initial begin
        // ---------------- reset with random inputs
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid     = 1'($urandom);
            in_a         = {$urandom, $urandom};
            in_d         = {$urandom, $urandom};
            in_propagate = 1'($urandom);
            in_shift     = SW'($urandom);
            in_last      = 1'($urandom);
            step();
            chk_eq("rst_out_a", out_a, 0);
            chk_eq("rst_out_d", out_d, 0);
            chk_eq("rst_out_shift", out_shift, 0);
            chk_eq("rst_ctrl", {out_propagate, out_valid, in_ready, busy}, 0);
        end
        RST = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        chk_eq("rst_release_ready", in_ready, 1);

        // ---------------- single 8-beat tile
        in_propagate = 1'b0;
        in_shift     = '0;
        for (int c = 0; c <= 17; c++) begin
            exp_v = '0;
            for (int i = 0; i < LANES; i++) if (c >= 1 + i && c <= 8 + i) exp_v[i] = 1'b1;
            chk_eq("t1_valid", out_valid, exp_v);
            for (int i = 0; i < LANES; i++)
                if (exp_v[i]) chk_eq("t1_lane_a", lane_a(i), 64'(16 * (c - 1 - i) + i));
            if (c == 15) begin
                chk_eq("t1_lane7_77", lane_a(7), 8'h77);
                chk_eq("t1_lane7_d", out_d[7*DW +: DW], 8'h88);
            end
            chk_eq("t1_ready", in_ready, (c >= 8 && c <= 14) ? 0 : 1);
            chk_eq("t1_busy", busy, (c >= 1 && c <= 15) ? 1 : 0);
            if (c < 8) begin
                in_valid = 1'b1;
                in_a     = pattern(c);
                in_d     = ~pattern(c);
                in_last  = (c == 7);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
        end
        wait_idle();

        // ---------------- bubble at slot 3 of a 6-beat tile
        for (int c = 0; c <= 13; c++) begin
            if (c >= 6 && c <= 12) begin
                chk_eq("t2_lane5_valid", out_valid[5], (c == 9) ? 0 : 1);
                if (c != 9) begin
                    chk_eq("t2_lane5_a", lane_a(5), 64'(16 * (c - 6) + 5));
                    chk_eq("t2_lane5_shift", lane_sh(5), 64'(c - 6));
                end else begin
`ifdef SKEW_ZERO_BUBBLE_EN
                    chk_eq("t2_bubble_a", lane_a(5), 8'h00);
                    chk_eq("t2_bubble_shift", lane_sh(5), 6'h00);
`else
                    chk_eq("t2_bubble_a", lane_a(5), 8'hEE);
                    chk_eq("t2_bubble_shift", lane_sh(5), 6'h3F);
`endif
                end
            end
            if (c == 3) begin
                in_valid = 1'b0;
                in_a     = {LANES{8'hEE}};
                in_shift = 6'h3F;
                in_last  = 1'b0;
            end else if (c <= 6) begin
                in_valid     = 1'b1;
                in_a         = pattern(c);
                in_shift     = SW'(c);
                in_propagate = 1'(c);
                in_last      = (c == 6);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
        end
        wait_idle();

        // ---------------- back-to-back tiles, in_valid held high
        tA = -100; tB = -100; pos = 0; viol = 0;
        for (int c = 0; c < 60; c++) begin
            for (int j = 0; j < LANES; j++)
                for (int k = j + 1; k < LANES; k++)
                    if (out_valid[j] && lane_sh(j) == 6'd5 && out_valid[k] && lane_sh(k) == 6'd3)
                        viol++;
            if (tA >= 0 && c == tA + 8)
                chk_eq("t3_a_tail_lane7", {out_valid[7], out_propagate[7], lane_sh(7)}, {1'b1, 1'b1, 6'd3});
            if (tA >= 0 && c == tA + 9)
                chk_eq("t3_b_head_lane0", {out_valid[0], out_propagate[0], lane_sh(0)}, {1'b1, 1'b0, 6'd5});
            if (pos < 16) begin
                in_valid     = 1'b1;
                in_a         = pattern(pos % 8);
                in_shift     = (pos < 8) ? 6'd3 : 6'd5;
                in_propagate = (pos < 8);
                in_last      = (pos == 7 || pos == 15);
                if (in_ready) begin
                    if (pos == 7) tA = c;
                    if (pos == 8) tB = c;
                    pos++;
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
        end
        chk_eq("t3_all_accepted", pos, 16);
        chk_eq("t3_gap", 64'(tB - tA), 8);
        chk_eq("t3_overlap", viol, 0);
        wait_idle();

        // ---------------- single-beat tile
        in_propagate = 1'b0;
        in_shift     = '0;
        for (int c = 0; c <= 9; c++) begin
            chk_eq("t4_ready", in_ready, (c >= 1 && c <= 7) ? 0 : 1);
            chk_eq("t4_valid", out_valid, (c >= 1 && c <= 8) ? 64'(1 << (c - 1)) : 64'd0);
            in_valid = (c == 0);
            in_last  = (c == 0);
            in_a     = pattern(9);
            step();
        end
        wait_idle();

        // ---------------- mid-tile reset
        for (int c = 0; c <= 4; c++) begin
            in_valid = 1'b1;
            in_a     = pattern(c);
            in_shift = 6'd7;
            in_last  = 1'b0;
            step();
        end
        in_a = pattern(5);
        #2;
        RST = 1'b1;
        #1;
        chk_eq("t5_rst_valid", out_valid, 0);
        chk_eq("t5_rst_a", out_a, 0);
        chk_eq("t5_rst_shift", out_shift, 0);
        chk_eq("t5_rst_ctrl", {out_propagate, in_ready, busy}, 0);
        step();
        step();
        in_valid = 1'b0;
        RST = 1'b0;
        chk_eq("t5_ready_still_low", in_ready, 0);
        step();
        chk_eq("t5_ready_after", in_ready, 1);
        viol = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid != 0 || busy) viol++;
            step();
        end
        chk_eq("t5_no_partial_wave", viol, 0);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = pattern(3);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_eq("t5_new_beat_lane0", {out_valid, lane_a(0)}, {8'h01, 8'h30});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
